// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT post-processing blocks.
package fft_pkg;

  localparam int FFT_DW     = 16;
  localparam int FFT_IDX_W  = 12;
  localparam int FFT_N_BINS = 4096;
  localparam int FFT_MAG_W  = FFT_DW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } pk_state_e;

endpackage

// File: rtl/fft_peak_detect_if.sv
// FFT bin stream into the peak finder and the per-frame peak result out of it.
interface fft_peak_detect_if import fft_pkg::*; #(
  parameter int DW    = FFT_DW,
  parameter int IDX_W = FFT_IDX_W
) ();

  logic signed [DW-1:0] s_real;
  logic signed [DW-1:0] s_imag;
  logic [IDX_W-1:0]     s_index;
  logic [7:0]           s_blk_exp;
  logic                 s_valid;

  logic [IDX_W-1:0]     peak_bin;
  logic [DW:0]          peak_mag;
  logic [7:0]           peak_exp;
  logic                 peak_valid;
  logic                 busy;

  modport master (
    output s_real, s_imag, s_index, s_blk_exp, s_valid,
    input  peak_bin, peak_mag, peak_exp, peak_valid, busy
  );

  modport slave (
    input  s_real, s_imag, s_index, s_blk_exp, s_valid,
    output peak_bin, peak_mag, peak_exp, peak_valid, busy
  );

endinterface

// File: rtl/mag_approx.sv
// Two-stage alpha-max-beta-min magnitude: saturated abs, then max + min/2.
// A sideband word travels alongside so callers can keep index/flags aligned.
module mag_approx import fft_pkg::*; #(
  parameter int DW   = FFT_DW,
  parameter int SB_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] re_i,
  input  logic signed [DW-1:0] im_i,
  input  logic [SB_W-1:0]      sb_i,
  output logic                 valid_o,
  output logic [DW:0]          mag_o,
  output logic [SB_W-1:0]      sb_o
);

  // The most negative code has no positive twin, so it clamps to full scale.
  function automatic logic [DW-2:0] sat_abs(input logic signed [DW-1:0] x);
    logic [DW-2:0] r;
    if (x == {1'b1, {(DW-1){1'b0}}}) r = {(DW-1){1'b1}};
    else if (x[DW-1])                r = (DW-1)'(-x);
    else                             r = x[DW-2:0];
    return r;
  endfunction

  logic            v1_q, v2_q;
  logic [DW-2:0]   are_d, aim_d, are_q, aim_q;
  logic [DW-2:0]   mx, mn;
  logic [DW:0]     mag_d, mag_q;
  logic [SB_W-1:0] sb1_q, sb2_q;

  always_comb begin
    are_d = sat_abs(re_i);
    aim_d = sat_abs(im_i);
    mx    = are_q;
    mn    = aim_q;
    if (aim_q > are_q) begin
      mx = aim_q;
      mn = are_q;
    end
    mag_d = {2'b00, mx} + {3'b000, mn[DW-2:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      v2_q <= v1_q;
    end
  end

  always_ff @(posedge clk) begin
    are_q <= are_d;
    aim_q <= aim_d;
    sb1_q <= sb_i;
    mag_q <= mag_d;
    sb2_q <= sb1_q;
  end

  assign valid_o = v2_q;
  assign mag_o   = mag_q;
  assign sb_o    = sb2_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak bin finder over a bin window of the FFT output stream.
// Define PEAK_AVG_EN to report the mean of the last four frame peak magnitudes.
module fft_peak_detect import fft_pkg::*; #(
  parameter int DW     = FFT_DW,
  parameter int IDX_W  = FFT_IDX_W,
  parameter int N_BINS = FFT_N_BINS,
  parameter int BIN_LO = 1,
  parameter int BIN_HI = 2047
) (
  input logic               clk,
  input logic               rst,
  fft_peak_detect_if.slave  bus
);

  localparam int MAG_W = DW + 1;
  localparam int SB_W  = IDX_W + 8 + 3;

  logic [31:0]      idx_ext;
  logic             first_in, last_in, win_in;
  logic [SB_W-1:0]  sb_in, sb2;
  logic             v2;
  logic [MAG_W-1:0] mag2;
  logic             first2, last2, win2;
  logic [7:0]       exp2;
  logic [IDX_W-1:0] idx2;

  always_comb begin
    idx_ext  = 32'(bus.s_index);
    first_in = (bus.s_index == '0);
    last_in  = (bus.s_index == IDX_W'(N_BINS - 1));
    win_in   = (idx_ext >= 32'(BIN_LO)) && (idx_ext <= 32'(BIN_HI));
    sb_in    = {first_in, last_in, win_in, bus.s_blk_exp, bus.s_index};
  end

  mag_approx #(.DW(DW), .SB_W(SB_W)) u_mag (
    .clk     (clk),
    .rst     (rst),
    .valid_i (bus.s_valid),
    .re_i    (bus.s_real),
    .im_i    (bus.s_imag),
    .sb_i    (sb_in),
    .valid_o (v2),
    .mag_o   (mag2),
    .sb_o    (sb2)
  );

  assign {first2, last2, win2, exp2, idx2} = sb2;

  pk_state_e        state_q, state_d;
  logic [MAG_W-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0] run_bin_q, run_bin_d;
  logic [IDX_W-1:0] peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
  logic [7:0]       peak_exp_q, peak_exp_d;
  logic             peak_valid_q, peak_valid_d;
  logic [MAG_W-1:0] base_max, cand_max, frame_mag;
  logic [IDX_W-1:0] base_bin, cand_bin;

  // A frame-start beat compares against a fresh accumulator, not the stale one.
  always_comb begin
    base_max = run_max_q;
    base_bin = run_bin_q;
    if (first2) begin
      base_max = '0;
      base_bin = IDX_W'(BIN_LO);
    end
    cand_max = base_max;
    cand_bin = base_bin;
    if (win2 && (mag2 > base_max)) begin
      cand_max = mag2;
      cand_bin = idx2;
    end
  end

`ifdef PEAK_AVG_EN
  logic [MAG_W-1:0] hist_q [3];
  logic [MAG_W+1:0] avg_sum;

  assign avg_sum   = (MAG_W+2)'(cand_max) + (MAG_W+2)'(hist_q[0])
                   + (MAG_W+2)'(hist_q[1]) + (MAG_W+2)'(hist_q[2]);
  assign frame_mag = avg_sum[MAG_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) hist_q[i] <= '0;
    end else if (peak_valid_d) begin
      hist_q[0] <= cand_max;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
    end
  end
`else
  assign frame_mag = cand_max;
`endif

  always_comb begin
    state_d      = state_q;
    run_max_d    = run_max_q;
    run_bin_d    = run_bin_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_exp_d   = peak_exp_q;
    peak_valid_d = 1'b0;
    if (v2) begin
      if (first2) begin
        state_d   = ST_ACC;
        run_max_d = cand_max;
        run_bin_d = cand_bin;
      end else if (state_q == ST_ACC) begin
        if (last2) begin
          state_d      = ST_IDLE;
          peak_bin_d   = cand_bin;
          peak_mag_d   = frame_mag;
          peak_exp_d   = exp2;
          peak_valid_d = 1'b1;
        end else begin
          run_max_d = cand_max;
          run_bin_d = cand_bin;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      run_max_q    <= '0;
      run_bin_q    <= '0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_exp_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_max_q    <= run_max_d;
      run_bin_q    <= run_bin_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_exp_q   <= peak_exp_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  assign bus.peak_bin   = peak_bin_q;
  assign bus.peak_mag   = peak_mag_q;
  assign bus.peak_exp   = peak_exp_q;
  assign bus.peak_valid = peak_valid_q;
  assign bus.busy       = (state_q == ST_ACC);

endmodule
